// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: FSM states, requester ids and
// counter sizing for the access sequencer.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    typedef enum logic {
        REQ_IF,
        REQ_LS
    } req_id_t;

    localparam int MEM_LAT_DEF = 1;
    localparam int CNT_W_DEF   = $clog2(MEM_LAT_DEF + 1);

    function automatic int cnt_w(input int lat);
        return (lat < 1) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant: a tie goes to the requester that did not
// win last time; a lone request always wins.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last_grant,
    output logic [1:0] grant
);

    logic last_ls;

    assign last_ls = (last_grant == REQ_LS);

    always_comb begin
        grant = 2'b00;
        unique case (1'b1)
            valid0 && !valid1:           grant = 2'b01;
            !valid0 && valid1:           grant = 2'b10;
            valid0 && valid1 && last_ls:  grant = 2'b01;
            valid0 && valid1 && !last_ls: grant = 2'b10;
            default:                     grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch / load-store arbiter and sequencer for the shared memory port.
// Optional MEM_ARB_ALIGN_CHK_EN: misaligned word access returns resp_err.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 16,
    parameter int MEM_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req_valid,
    input  logic [DEPTH-1:0] if_req_addr,
    output logic             if_req_ready,
    output logic             if_resp_valid,
    input  logic             ls_req_valid,
    input  logic             ls_req_we,
    input  logic [DEPTH-1:0] ls_req_addr,
    input  logic [WIDTH-1:0] ls_req_wdata,
    output logic             ls_req_ready,
    output logic             ls_resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err,
    output logic [DEPTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_data_in,
    output logic             mem_rd,
    output logic             mem_wr,
    input  logic [WIDTH-1:0] mem_data_out
);

    localparam int CW = cnt_w(MEM_LAT);
    localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

    state_t           state_q;
    state_t           state_d;
    req_id_t          last_q;
    req_id_t          owner_q;
    logic             we_q;
    logic [DEPTH-1:0] addr_q;
    logic [WIDTH-1:0] wdata_q;
    logic [WIDTH-1:0] rdata_q;
    logic [CW-1:0]    cnt_q;
    logic [1:0]       gnt;
    logic             take;
    logic             misalign;
    logic [DEPTH-1:0] gnt_addr;

    rr_arb2 u_arb (
        .valid0     (if_req_valid),
        .valid1     (ls_req_valid),
        .last_grant (last_q),
        .grant      (gnt)
    );

    assign take     = !rst && (state_q == IDLE) && (gnt != 2'b00);
    assign gnt_addr = gnt[1] ? ls_req_addr : if_req_addr;

`ifdef MEM_ARB_ALIGN_CHK_EN
    logic err_q;

    assign misalign = (gnt_addr[1:0] != 2'b00);
    assign resp_err = err_q && (if_resp_valid || ls_resp_valid);
`else
    assign misalign = 1'b0;
    assign resp_err = 1'b0;
`endif

    assign mem_addr    = addr_q;
    assign mem_data_in = wdata_q;
    assign resp_rdata  = rdata_q;

    // Every strobe is gated by rst so an aborted transfer emits nothing.
    always_comb begin
        state_d       = state_q;
        if_req_ready  = 1'b0;
        ls_req_ready  = 1'b0;
        if_resp_valid = 1'b0;
        ls_resp_valid = 1'b0;
        mem_rd        = 1'b0;
        mem_wr        = 1'b0;
        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    if (gnt != 2'b00) begin
                        if_req_ready = gnt[0];
                        ls_req_ready = gnt[1];
                        state_d      = misalign ? RESP : ACCESS;
                    end
                end
                ACCESS: begin
                    mem_rd = !we_q;
                    mem_wr = we_q && (cnt_q == '0);
                    if (cnt_q == '0) begin
                        state_d = RESP;
                    end
                end
                RESP: begin
                    if_resp_valid = (owner_q == REQ_IF);
                    ls_resp_valid = (owner_q == REQ_LS);
                    state_d       = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= REQ_LS;
            owner_q <= REQ_IF;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                owner_q <= gnt[1] ? REQ_LS : REQ_IF;
                last_q  <= gnt[1] ? REQ_LS : REQ_IF;
                we_q    <= gnt[1] && ls_req_we;
                addr_q  <= gnt_addr;
                wdata_q <= gnt[1] ? ls_req_wdata : '0;
                cnt_q   <= CNT_INIT;
                if (misalign) begin
                    rdata_q <= '0;
                end
            end
            if (state_q == ACCESS) begin
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - CW'(1);
                end else begin
                    rdata_q <= we_q ? '0 : mem_data_out;
                end
            end
        end
    end

`ifdef MEM_ARB_ALIGN_CHK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (take) begin
            err_q <= misalign;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at MEM_LAT=1 (a_*) and one
// at MEM_LAT=3 (b_*), each with a word-indexed behavioural memory.
module tb_mem_arbiter;

    localparam int W = 32;
    localparam int D = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    int nvec = 0;
    int nbad = 0;

    logic         a_if_v, a_if_rdy, a_if_rv;
    logic         a_ls_v, a_ls_we, a_ls_rdy, a_ls_rv;
    logic         a_err, a_rd, a_wr;
    logic [D-1:0] a_if_addr, a_ls_addr, a_maddr;
    logic [W-1:0] a_ls_wd, a_rdata, a_mdin, a_mdout;
    logic [W-1:0] a_mem [0:255];

    logic         b_if_v, b_if_rdy, b_if_rv;
    logic         b_ls_v, b_ls_we, b_ls_rdy, b_ls_rv;
    logic         b_err, b_rd, b_wr;
    logic [D-1:0] b_if_addr, b_ls_addr, b_maddr;
    logic [W-1:0] b_ls_wd, b_rdata, b_mdin, b_mdout;
    logic [W-1:0] b_mem [0:255];

    assign a_mdout = a_mem[a_maddr[9:2]];
    assign b_mdout = b_mem[b_maddr[9:2]];

    always @(posedge clk) begin
        if (a_wr) a_mem[a_maddr[9:2]] <= a_mdin;
        if (b_wr) b_mem[b_maddr[9:2]] <= b_mdin;
    end

    mem_arbiter #(.WIDTH(W), .DEPTH(D), .MEM_LAT(1)) u_a (
        .clk           (clk),
        .rst           (rst),
        .if_req_valid  (a_if_v),
        .if_req_addr   (a_if_addr),
        .if_req_ready  (a_if_rdy),
        .if_resp_valid (a_if_rv),
        .ls_req_valid  (a_ls_v),
        .ls_req_we     (a_ls_we),
        .ls_req_addr   (a_ls_addr),
        .ls_req_wdata  (a_ls_wd),
        .ls_req_ready  (a_ls_rdy),
        .ls_resp_valid (a_ls_rv),
        .resp_rdata    (a_rdata),
        .resp_err      (a_err),
        .mem_addr      (a_maddr),
        .mem_data_in   (a_mdin),
        .mem_rd        (a_rd),
        .mem_wr        (a_wr),
        .mem_data_out  (a_mdout)
    );

    mem_arbiter #(.WIDTH(W), .DEPTH(D), .MEM_LAT(3)) u_b (
        .clk           (clk),
        .rst           (rst),
        .if_req_valid  (b_if_v),
        .if_req_addr   (b_if_addr),
        .if_req_ready  (b_if_rdy),
        .if_resp_valid (b_if_rv),
        .ls_req_valid  (b_ls_v),
        .ls_req_we     (b_ls_we),
        .ls_req_addr   (b_ls_addr),
        .ls_req_wdata  (b_ls_wd),
        .ls_req_ready  (b_ls_rdy),
        .ls_resp_valid (b_ls_rv),
        .resp_rdata    (b_rdata),
        .resp_err      (b_err),
        .mem_addr      (b_maddr),
        .mem_data_in   (b_mdin),
        .mem_rd        (b_rd),
        .mem_wr        (b_wr),
        .mem_data_out  (b_mdout)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    int gq_c[$], gq_id[$], rq_c[$], rq_id[$];
    logic [31:0] rq_d[$];
    int exp_gc[4] = '{0, 3, 6, 9};
    int exp_rc[4] = '{2, 5, 8, 11};
    int exp_id[4] = '{0, 1, 0, 1};
    logic [31:0] exp_rd[4];
    int seen;

    initial begin
        for (int i = 0; i < 256; i++) begin
            a_mem[i] = '0;
            b_mem[i] = '0;
        end
        a_mem[1] = 32'hDEADBEEF;
        a_mem[2] = 32'h22222222;
        b_mem[3] = 32'h0C0C0C0C;
        b_mem[8] = 32'h55AA55AA;
        exp_rd = '{32'hDEADBEEF, 32'h22222222, 32'hDEADBEEF, 32'h22222222};
        {a_if_v, a_ls_v, a_ls_we, b_if_v, b_ls_v, b_ls_we} = '0;
        {a_if_addr, a_ls_addr, b_if_addr, b_ls_addr} = '0;
        {a_ls_wd, b_ls_wd} = '0;

        // Reset state
        rst = 1'b1;
        cyc;
        cyc;
        smp;
        chk("rst a_rdy", {a_if_rdy, a_ls_rdy}, 0);
        chk("rst a_rv", {a_if_rv, a_ls_rv, a_err}, 0);
        chk("rst a_strobe", {a_rd, a_wr}, 0);
        chk("rst a_addr", a_maddr, 0);
        chk("rst a_rdata", a_rdata, 0);
        chk("rst b_strobe", {b_rd, b_wr, b_if_rv, b_ls_rv}, 0);
        cyc;
        rst = 1'b0;

        // Fetch read, MEM_LAT=1
        a_if_v = 1'b1;
        a_if_addr = 16'h0004;
        smp;
        chk("f1 if_ready", a_if_rdy, 1);
        cyc;
        a_if_v = 1'b0;
        smp;
        chk("f1 mem_rd", a_rd, 1);
        chk("f1 mem_addr", a_maddr, 16'h0004);
        chk("f1 early rv", a_if_rv, 0);
        cyc;
        smp;
        chk("f1 if_rv", a_if_rv, 1);
        chk("f1 ls_rv", a_ls_rv, 0);
        chk("f1 rdata", a_rdata, 32'hDEADBEEF);
        cyc;

        // Misaligned load at 0x0006
        a_ls_v = 1'b1;
        a_ls_we = 1'b0;
        a_ls_addr = 16'h0006;
        smp;
        chk("mis ls_ready", a_ls_rdy, 1);
        cyc;
        a_ls_v = 1'b0;
        smp;
`ifdef MEM_ARB_ALIGN_CHK_EN
        chk("mis mem_rd", a_rd, 0);
        chk("mis ls_rv", a_ls_rv, 1);
        chk("mis err", a_err, 1);
        chk("mis rdata", a_rdata, 0);
`else
        chk("mis mem_rd", a_rd, 1);
        chk("mis mem_addr", a_maddr, 16'h0006);
        cyc;
        smp;
        chk("mis ls_rv", a_ls_rv, 1);
        chk("mis err", a_err, 0);
        chk("mis rdata", a_rdata, 32'hDEADBEEF);
`endif
        cyc;

        // Round-robin from reset with both requesters always valid
        rst = 1'b1;
        cyc;
        rst = 1'b0;
        a_if_v = 1'b1;
        a_if_addr = 16'h0004;
        a_ls_v = 1'b1;
        a_ls_we = 1'b0;
        a_ls_addr = 16'h0008;
        for (int c = 0; c < 12; c++) begin
            smp;
            if (a_if_rdy) begin gq_c.push_back(c); gq_id.push_back(0); end
            if (a_ls_rdy) begin gq_c.push_back(c); gq_id.push_back(1); end
            if (a_if_rv) begin
                rq_c.push_back(c); rq_id.push_back(0); rq_d.push_back(a_rdata);
            end
            if (a_ls_rv) begin
                rq_c.push_back(c); rq_id.push_back(1); rq_d.push_back(a_rdata);
            end
            cyc;
        end
        a_if_v = 1'b0;
        a_ls_v = 1'b0;
        chk("rr grants", gq_c.size(), 4);
        chk("rr resps", rq_c.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < gq_c.size()) begin
                chk("rr gnt cyc", gq_c[i], exp_gc[i]);
                chk("rr gnt id", gq_id[i], exp_id[i]);
            end
            if (i < rq_c.size()) begin
                chk("rr rsp cyc", rq_c[i], exp_rc[i]);
                chk("rr rsp id", rq_id[i], exp_id[i]);
                chk("rr rsp data", rq_d[i], exp_rd[i]);
            end
        end

        // Store with MEM_LAT=3, then read it back by fetch
        b_ls_v = 1'b1;
        b_ls_we = 1'b1;
        b_ls_addr = 16'h0010;
        b_ls_wd = 32'h12345678;
        smp;
        chk("st ls_ready", b_ls_rdy, 1);
        cyc;
        b_ls_v = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            smp;
            chk("st mem_wr", b_wr, (k == 3) ? 1 : 0);
            chk("st mem_rd", b_rd, 0);
            if (k == 3) begin
                chk("st mem_addr", b_maddr, 16'h0010);
                chk("st mem_din", b_mdin, 32'h12345678);
            end
            cyc;
        end
        smp;
        chk("st ls_rv", b_ls_rv, 1);
        cyc;
        b_if_v = 1'b1;
        b_if_addr = 16'h0010;
        smp;
        chk("rb if_ready", b_if_rdy, 1);
        cyc;
        b_if_v = 1'b0;
        cyc;
        cyc;
        cyc;
        smp;
        chk("rb if_rv", b_if_rv, 1);
        chk("rb rdata", b_rdata, 32'h12345678);
        cyc;

        // Fetch held while a load is in flight
        b_ls_v = 1'b1;
        b_ls_we = 1'b0;
        b_ls_addr = 16'h0010;
        smp;
        chk("hold ls_ready", b_ls_rdy, 1);
        cyc;
        b_ls_v = 1'b0;
        b_if_v = 1'b1;
        b_if_addr = 16'h000C;
        for (int k = 1; k <= 3; k++) begin
            smp;
            chk("hold if_rdy early", b_if_rdy, 0);
            cyc;
        end
        smp;
        chk("hold ls_rv", b_ls_rv, 1);
        chk("hold ls rdata", b_rdata, 32'h12345678);
        chk("hold if_rdy resp", b_if_rdy, 0);
        cyc;
        smp;
        chk("hold if_ready", b_if_rdy, 1);
        cyc;
        b_if_v = 1'b0;
        smp;
        chk("hold mem_addr", b_maddr, 16'h000C);
        chk("hold mem_rd", b_rd, 1);
        cyc;
        cyc;
        cyc;
        smp;
        chk("hold if_rv", b_if_rv, 1);
        chk("hold if rdata", b_rdata, 32'h0C0C0C0C);
        cyc;

        // Reset during ACCESS of a store
        b_ls_v = 1'b1;
        b_ls_we = 1'b1;
        b_ls_addr = 16'h0020;
        b_ls_wd = 32'hCAFEF00D;
        smp;
        chk("ab ls_ready", b_ls_rdy, 1);
        cyc;
        b_ls_v = 1'b0;
        rst = 1'b1;
        smp;
        chk("ab wr in rst", b_wr, 0);
        cyc;
        rst = 1'b0;
        smp;
        chk("ab rdy", {b_if_rdy, b_ls_rdy}, 0);
        chk("ab rv", {b_if_rv, b_ls_rv, b_err}, 0);
        chk("ab strobe", {b_rd, b_wr}, 0);
        chk("ab mem_addr", b_maddr, 0);
        chk("ab mem_din", b_mdin, 0);
        chk("ab rdata", b_rdata, 0);
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            cyc;
            smp;
            if (b_wr || b_ls_rv || b_if_rv) seen++;
        end
        chk("ab no activity", seen, 0);
        chk("ab mem intact", b_mem[8], 32'h55AA55AA);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the shared byte-addressed program/data memory port of the multicycle core.
- Requester 0 is instruction fetch (read-only). Requester 1 is the load/store unit (read/write).
- Serialises accesses, drives the memory's rd/wr/addr/data_in strobes for a programmable number of cycles, and returns the captured data_out to the winner with a one-cycle response pulse.

Parameters:
- WIDTH, 32: data word width in bits.
- DEPTH, 16: address width in bits (memory holds 2**DEPTH bytes).
- MEM_LAT, 1: number of access cycles per transaction; must be >= 1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req_valid  in  1  fetch request; held stable until if_req_ready.
- if_req_addr  in  DEPTH  fetch byte address.
- if_req_ready  out  1  one-cycle accept pulse to fetch.
- if_resp_valid  out  1  one-cycle response pulse to fetch.
- ls_req_valid  in  1  load/store request; held stable until ls_req_ready.
- ls_req_we  in  1  1 = store, 0 = load.
- ls_req_addr  in  DEPTH  load/store byte address.
- ls_req_wdata  in  WIDTH  store data.
- ls_req_ready  out  1  one-cycle accept pulse to load/store.
- ls_resp_valid  out  1  one-cycle response pulse to load/store (also sent for stores).
- resp_rdata  out  WIDTH  read data; valid only while a resp_valid is high.
- resp_err  out  1  error flag, qualified by resp_valid (see Optional Feature).
- mem_addr  out  DEPTH  memory address.
- mem_data_in  out  WIDTH  memory write data.
- mem_rd  out  1  memory read enable.
- mem_wr  out  1  memory write enable.
- mem_data_out  in  WIDTH  combinational read data from memory.

Behaviour:
- States: IDLE, ACCESS, RESP.
- Reset: state=IDLE. All ready/valid/rd/wr/err outputs = 0. mem_addr, mem_data_in, resp_rdata = 0. last_grant = LS, so fetch wins the first tie.
- IDLE, no valid requests: stay in IDLE. No strobes.
- IDLE, one requester valid: grant that requester.
- IDLE, both valid: round-robin. Grant the requester that is not last_grant, then update last_grant.
- Grant cycle T:
  - req_ready of the winner = 1 for exactly this cycle.
  - Latch addr, we, wdata (wdata = 0 for fetch) into internal registers.
  - Load cnt = MEM_LAT-1; go to ACCESS.
- ACCESS:
  - mem_addr and mem_data_in driven from the latched registers.
  - Read: mem_rd = 1 on every ACCESS cycle.
  - Write: mem_wr = 1 only on the final ACCESS cycle (cnt==0); mem_rd = 0.
  - cnt decrements each cycle. At cnt==0, capture mem_data_out into resp_rdata (captured value is 0 for a write); go to RESP.
- RESP: the winner's resp_valid = 1 for one cycle; go to IDLE.
- Latency: accept at T, response at T+MEM_LAT+1. Throughput: one transaction per MEM_LAT+2 cycles.
- Outside ACCESS: mem_rd = mem_wr = 0. mem_addr and mem_data_in hold their last values.
- Requests arriving during ACCESS/RESP wait; they are never dropped. A requester must not deassert valid before ready.
- Never more than one ready or resp_valid asserted in the same cycle.
- Reset mid-transaction: abort immediately. No response is issued. A write whose final ACCESS cycle has not been reached is never performed.
- Address arithmetic: DEPTH-bit, no wrap handling needed. Word data occupies addr..addr+3 bytes, little-endian; the memory handles the byte ordering.

Optional Feature:
- Macro: MEM_ARB_ALIGN_CHK_EN.
- Defined:
  - At grant, if latched addr[1:0] != 0, skip ACCESS and go straight to RESP, with no mem_rd/mem_wr.
  - resp_err = 1 and resp_rdata = 0. Response therefore arrives at T+1.
- Undefined: no check is made; resp_err is tied to 0 and misaligned addresses pass through to memory.

Decomposition:
- Shared package mem_arb_pkg:
  - state enum {IDLE, ACCESS, RESP}.
  - requester ID enum {REQ_IF, REQ_LS}.
  - localparam for the counter width, $clog2(MEM_LAT+1).
- Sub-module rr_arb2: two-input round-robin grant logic (inputs: two valids and last_grant; output: one-hot grant).

Test Plan:
- Fetch read, MEM_LAT=1, addr 0x0004, memory word 0xDEADBEEF -> if_req_ready at T, mem_rd at T+1, if_resp_valid with resp_rdata=0xDEADBEEF at T+2.
- Store at addr 0x0010, wdata 0x12345678, MEM_LAT=3 -> mem_wr=1 only at T+3 with mem_addr=0x0010. ls_resp_valid at T+4. A later fetch of 0x0010 returns 0x12345678.
- Both valid every cycle from reset -> grants alternate IF, LS, IF, LS. The 4 responses arrive in that order, MEM_LAT+2 cycles apart.
- rst asserted for one cycle during ACCESS of a store, MEM_LAT=3 -> no mem_wr pulse and no resp_valid. All outputs are 0 the cycle after the reset.
- Fetch valid held during an LS transaction -> if_req_ready occurs in the cycle right after ls_resp_valid (the IDLE cycle). Fetch address is unchanged.
- With MEM_ARB_ALIGN_CHK_EN, load addr 0x0006 -> no mem_rd. ls_resp_valid at T+1 with resp_err=1 and resp_rdata=0.
